control_sequencer: RTL and testbench

//  Microcoded control unit for the 8-bit bus computer. Steps a T-state counter,

---
 rtl/control_sequencer.sv | 132 +++++++++++++
 tb/tb_control_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Microcoded control sequencer for the 8-bit bus computer: T-state counter, opcode/flag decode,
// and the 16 control lines. Optional `define EARLY_END_EN ends an instruction once its remaining microwords are empty.
module control_sequencer #(
    parameter int unsigned OPW   = 4,
    parameter int unsigned STEPS = 5,
    parameter int unsigned SW    = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           run,
    input  logic [OPW-1:0] op,
    input  logic           cf,
    input  logic           zf,
    output logic           hlt,
    output logic           mi,
    output logic           ri,
    output logic           ro,
    output logic           io,
    output logic           ii,
    output logic           ai,
    output logic           ao,
    output logic           eo,
    output logic           su,
    output logic           bi,
    output logic           oi,
    output logic           ce,
    output logic           co,
    output logic           j,
    output logic           fi,
    output logic [SW-1:0]  step,
    output logic           halted
);

    localparam logic [15:0] CHlt = 16'h8000, CMi = 16'h4000, CRi = 16'h2000, CRo = 16'h1000;
    localparam logic [15:0] CIo  = 16'h0800, CIi = 16'h0400, CAi = 16'h0200, CAo = 16'h0100;
    localparam logic [15:0] CEo  = 16'h0080, CSu = 16'h0040, CBi = 16'h0020, COi = 16'h0010;
    localparam logic [15:0] CCe  = 16'h0008, CCo = 16'h0004, CJ  = 16'h0002, CFi = 16'h0001;

    localparam logic [OPW-1:0] OpLda = OPW'(1),  OpAdd = OPW'(2),  OpSub = OPW'(3);
    localparam logic [OPW-1:0] OpSta = OPW'(4),  OpLdi = OPW'(5),  OpJmp = OPW'(6);
    localparam logic [OPW-1:0] OpJc  = OPW'(7),  OpJz  = OPW'(8),  OpOut = OPW'(14);
    localparam logic [OPW-1:0] OpHlt = OPW'(15);

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   step_q, step_d;
    logic [15:0]     ctrl;
    logic            early_end;

    function automatic logic [15:0] microword(input logic [SW-1:0] t, input logic [OPW-1:0] o,
                                              input logic c, input logic z);
        logic [15:0] w;
        w = '0;
        case (t)
            SW'(0): w = CCo | CMi;
            SW'(1): w = CRo | CIi | CCe;
            SW'(2): begin
                case (o)
                    OpLda, OpAdd, OpSub, OpSta: w = CIo | CMi;
                    OpLdi: w = CIo | CAi;
                    OpJmp: w = CIo | CJ;
                    OpJc:  w = c ? (CIo | CJ) : '0;
                    OpJz:  w = z ? (CIo | CJ) : '0;
                    OpOut: w = CAo | COi;
                    OpHlt: w = CHlt;
                    default: w = '0;
                endcase
            end
            SW'(3): begin
                case (o)
                    OpLda:        w = CRo | CAi;
                    OpAdd, OpSub: w = CRo | CBi;
                    OpSta:        w = CAo | CRi;
                    default:      w = '0;
                endcase
            end
            SW'(4): begin
                case (o)
                    OpAdd:   w = CEo | CAi | CFi;
                    OpSub:   w = CEo | CAi | CSu | CFi;
                    default: w = '0;
                endcase
            end
            default: w = '0;
        endcase
        return w;
    endfunction

`ifdef EARLY_END_EN
    // Execute microcode has no gaps, so an empty next word means the instruction is done.
    assign early_end = (step_q >= SW'(2)) && (microword(step_q + SW'(1), op, cf, zf) == '0);
`else
    assign early_end = 1'b0;
`endif

    always_ff @(posedge clk) begin
        state_q <= state_d;
        step_q  <= step_d;
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        if (reset) begin
            state_d = StRun;
            step_d  = '0;
        end else if (!run) begin
            step_d = '0;
        end else if (state_q == StRun) begin
            if (step_q == SW'(2) && op == OpHlt) begin
                state_d = StHalted;
            end else if (step_q == SW'(STEPS - 1) || early_end) begin
                step_d = '0;
            end else begin
                step_d = step_q + SW'(1);
            end
        end
    end

    always_comb begin
        ctrl = '0;
        if (!reset && run) begin
            ctrl = (state_q == StHalted) ? CHlt : microword(step_q, op, cf, zf);
        end
        halted = (state_q == StHalted) && !reset;
        step   = step_q;
    end

    assign {hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi} = ctrl;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle expectations queued, then checked
// against the combinational controls, step and halted.
module tb_control_sequencer;

    localparam logic [15:0] KHlt = 16'h8000, KMi = 16'h4000, KRi = 16'h2000, KRo = 16'h1000;
    localparam logic [15:0] KIo  = 16'h0800, KIi = 16'h0400, KAi = 16'h0200, KAo = 16'h0100;
    localparam logic [15:0] KEo  = 16'h0080, KSu = 16'h0040, KBi = 16'h0020, KOi = 16'h0010;
    localparam logic [15:0] KCe  = 16'h0008, KCo = 16'h0004, KJ  = 16'h0002, KFi = 16'h0001;
    localparam logic [15:0] KT0  = KCo | KMi;
    localparam logic [15:0] KT1  = KRo | KIi | KCe;

    logic clk = 1'b0;
    logic reset, run, cf, zf;
    logic [3:0] op;
    logic hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi;
    logic [2:0] step;
    logic halted;
    logic [15:0] ctl;

    typedef struct {
        string       tag;
        logic [15:0] ctl;
        logic [2:0]  st;
        logic        h;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .op(op), .cf(cf), .zf(zf),
        .hlt(hlt), .mi(mi), .ri(ri), .ro(ro), .io(io), .ii(ii), .ai(ai), .ao(ao),
        .eo(eo), .su(su), .bi(bi), .oi(oi), .ce(ce), .co(co), .j(j), .fi(fi),
        .step(step), .halted(halted)
    );

    assign ctl = {hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi};

    // Inputs are already set for this cycle; push expectation, let comb settle, compare, advance.
    task automatic cycle(input string tag, input logic [15:0] ec, input logic [2:0] es,
                         input logic eh);
        exp_t e;
        sb.push_back('{tag, ec, es, eh});
        #2;
        e = sb.pop_front();
        n_cmp++;
        assert (ctl === e.ctl) else begin
            n_err++;
            $error("FAIL %s ctl: observed %h expected %h", e.tag, ctl, e.ctl);
        end
        n_cmp++;
        assert (step === e.st) else begin
            n_err++;
            $error("FAIL %s step: observed %0d expected %0d", e.tag, step, e.st);
        end
        n_cmp++;
        assert (halted === e.h) else begin
            n_err++;
            $error("FAIL %s halted: observed %b expected %b", e.tag, halted, e.h);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; run = 1'b1; op = 4'b0000; cf = 1'b0; zf = 1'b0;
        @(posedge clk);
        #1;
        cycle("reset", 16'h0, 3'd0, 1'b0);
        reset = 1'b0;

        op = 4'b0001;
        cycle("lda_t0", KT0, 3'd0, 1'b0);
        cycle("lda_t1", KT1, 3'd1, 1'b0);
        cycle("lda_t2", KIo | KMi, 3'd2, 1'b0);
        cycle("lda_t3", KRo | KAi, 3'd3, 1'b0);
`ifndef EARLY_END_EN
        cycle("lda_t4", 16'h0, 3'd4, 1'b0);
`endif

        op = 4'b0011;
        cycle("sub_t0", KT0, 3'd0, 1'b0);
        cycle("sub_t1", KT1, 3'd1, 1'b0);
        cycle("sub_t2", KIo | KMi, 3'd2, 1'b0);
        cycle("sub_t3", KRo | KBi, 3'd3, 1'b0);
        cycle("sub_t4", KEo | KAi | KSu | KFi, 3'd4, 1'b0);

        op = 4'b0111; cf = 1'b0;
        cycle("jc0_t0", KT0, 3'd0, 1'b0);
        cycle("jc0_t1", KT1, 3'd1, 1'b0);
        cycle("jc0_t2", 16'h0, 3'd2, 1'b0);
`ifndef EARLY_END_EN
        cycle("jc0_t3", 16'h0, 3'd3, 1'b0);
        cycle("jc0_t4", 16'h0, 3'd4, 1'b0);
`endif
        cf = 1'b1;
        cycle("jc1_t0", KT0, 3'd0, 1'b0);
        cycle("jc1_t1", KT1, 3'd1, 1'b0);
        cycle("jc1_t2", KIo | KJ, 3'd2, 1'b0);
`ifndef EARLY_END_EN
        cycle("jc1_t3", 16'h0, 3'd3, 1'b0);
        cycle("jc1_t4", 16'h0, 3'd4, 1'b0);
`endif

        op = 4'b1000; cf = 1'b1; zf = 1'b0;
        cycle("jz0_t0", KT0, 3'd0, 1'b0);
        cycle("jz0_t1", KT1, 3'd1, 1'b0);
        cycle("jz0_t2", 16'h0, 3'd2, 1'b0);
`ifndef EARLY_END_EN
        cycle("jz0_t3", 16'h0, 3'd3, 1'b0);
        cycle("jz0_t4", 16'h0, 3'd4, 1'b0);
`endif
        zf = 1'b1; cf = 1'b0;
        cycle("jz1_t0", KT0, 3'd0, 1'b0);
        cycle("jz1_t1", KT1, 3'd1, 1'b0);
        cycle("jz1_t2", KIo | KJ, 3'd2, 1'b0);
`ifndef EARLY_END_EN
        cycle("jz1_t3", 16'h0, 3'd3, 1'b0);
        cycle("jz1_t4", 16'h0, 3'd4, 1'b0);
`endif

        op = 4'b0101;
        cycle("ldi_t0", KT0, 3'd0, 1'b0);
        cycle("ldi_t1", KT1, 3'd1, 1'b0);
        cycle("ldi_t2", KIo | KAi, 3'd2, 1'b0);
`ifndef EARLY_END_EN
        cycle("ldi_t3", 16'h0, 3'd3, 1'b0);
        cycle("ldi_t4", 16'h0, 3'd4, 1'b0);
`endif

        op = 4'b0100;
        cycle("sta_t0", KT0, 3'd0, 1'b0);
        cycle("sta_t1", KT1, 3'd1, 1'b0);
        cycle("sta_t2", KIo | KMi, 3'd2, 1'b0);
        cycle("sta_t3", KAo | KRi, 3'd3, 1'b0);
`ifndef EARLY_END_EN
        cycle("sta_t4", 16'h0, 3'd4, 1'b0);
`endif

        // Drop run mid-ADD, then resume from T0.
        op = 4'b0010;
        cycle("add_t0", KT0, 3'd0, 1'b0);
        cycle("add_t1", KT1, 3'd1, 1'b0);
        cycle("add_t2", KIo | KMi, 3'd2, 1'b0);
        run = 1'b0;
        cycle("add_stop", 16'h0, 3'd3, 1'b0);
        cycle("prog_mode", 16'h0, 3'd0, 1'b0);
        run = 1'b1;
        cycle("add2_t0", KT0, 3'd0, 1'b0);
        cycle("add2_t1", KT1, 3'd1, 1'b0);
        cycle("add2_t2", KIo | KMi, 3'd2, 1'b0);
        cycle("add2_t3", KRo | KBi, 3'd3, 1'b0);
        cycle("add2_t4", KEo | KAi | KFi, 3'd4, 1'b0);

        op = 4'b1110;
        cycle("out_t0", KT0, 3'd0, 1'b0);
        cycle("out_t1", KT1, 3'd1, 1'b0);
        cycle("out_t2", KAo | KOi, 3'd2, 1'b0);
`ifndef EARLY_END_EN
        cycle("out_t3", 16'h0, 3'd3, 1'b0);
        cycle("out_t4", 16'h0, 3'd4, 1'b0);
`endif

        op = 4'b1010;
        cycle("nop_t0", KT0, 3'd0, 1'b0);
        cycle("nop_t1", KT1, 3'd1, 1'b0);
        cycle("nop_t2", 16'h0, 3'd2, 1'b0);
`ifndef EARLY_END_EN
        cycle("nop_t3", 16'h0, 3'd3, 1'b0);
        cycle("nop_t4", 16'h0, 3'd4, 1'b0);
`endif

        op = 4'b1111;
        cycle("hlt_t0", KT0, 3'd0, 1'b0);
        cycle("hlt_t1", KT1, 3'd1, 1'b0);
        cycle("hlt_t2", KHlt, 3'd2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle("halted", KHlt, 3'd2, 1'b1);
        end
        reset = 1'b1;
        cycle("hlt_reset", 16'h0, 3'd2, 1'b0);
        reset = 1'b0; op = 4'b0001;
        cycle("post_rst_t0", KT0, 3'd0, 1'b0);
        cycle("post_rst_t1", KT1, 3'd1, 1'b0);

        // Reset mid-instruction aborts it.
        reset = 1'b1;
        cycle("abort_rst", 16'h0, 3'd2, 1'b0);
        reset = 1'b0;
        cycle("abort_t0", KT0, 3'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
